// File: rtl/lbdr_pkg.sv
// Shared types and constants for the LBDR route-computation stage.
// Port vector bit order is {L,S,W,E,N}.
package lbdr_pkg;

    localparam int unsigned P_N   = 0;
    localparam int unsigned P_E   = 1;
    localparam int unsigned P_W   = 2;
    localparam int unsigned P_S   = 3;
    localparam int unsigned P_L   = 4;
    localparam int unsigned PORTS = 5;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned RXY_W = 8;
    localparam int unsigned CX_W  = 4;

    localparam logic [ID_W-1:0] FLIT_HEADER  = 3'b001;
    localparam logic [ID_W-1:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [ID_W-1:0] FLIT_TAIL    = 3'b100;

    typedef logic [PORTS-1:0] port_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } lbdr_state_t;

    typedef struct packed {
        logic rsw;
        logic rse;
        logic rws;
        logic rwn;
        logic res;
        logic ren;
        logic rnw;
        logic rne;
    } rxy_t;

    typedef struct packed {
        logic cs;
        logic cw;
        logic ce;
        logic cn;
    } cx_t;

endpackage

// File: rtl/lbdr_route_stage_if.sv
// Flit handshake bundle of the route stage: input side from the buffer,
// output side towards the switch allocator.
interface lbdr_route_stage_if #(
    parameter int unsigned XW = 2,
    parameter int unsigned YW = 2,
    parameter int unsigned DW = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [lbdr_pkg::ID_W-1:0]  in_id;
    logic [XW+YW-1:0]           in_dst;
    logic [DW-1:0]              in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [lbdr_pkg::ID_W-1:0]  out_id;
    logic [DW-1:0]              out_data;
    lbdr_pkg::port_vec_t        out_port;

    modport master (
        output in_valid, in_id, in_dst, in_data, out_ready,
        input  in_ready, out_valid, out_id, out_data, out_port
    );

    modport slave (
        input  in_valid, in_id, in_dst, in_data, out_ready,
        output in_ready, out_valid, out_id, out_data, out_port
    );
endinterface

// File: rtl/lbdr_route_calc.sv
// Combinational minimal LBDR port computation; with LBDR_DEROUTE_EN an
// unroutable destination falls back to one connected deroute port.
module lbdr_route_calc
    import lbdr_pkg::*;
#(
    parameter int unsigned XW = 2,
    parameter int unsigned YW = 2
) (
    input  logic [XW+YW-1:0] dst,
    input  logic [XW+YW-1:0] cur,
    input  rxy_t             rxy,
    input  cx_t              cx,
`ifdef LBDR_DEROUTE_EN
    input  logic [RXY_W-1:0] drt,
`endif
    output port_vec_t        route
);
    logic [XW-1:0] xd, xc;
    logic [YW-1:0] yd, yc;
    logic          n1, e1, w1, s1;
    port_vec_t     min_vec;

    assign xd = dst[XW-1:0];
    assign yd = dst[XW+YW-1:XW];
    assign xc = cur[XW-1:0];
    assign yc = cur[XW+YW-1:XW];

    // North is towards smaller y, east towards larger x
    assign n1 = yd < yc;
    assign s1 = yc < yd;
    assign e1 = xc < xd;
    assign w1 = xd < xc;

    always_comb begin
        min_vec        = '0;
        min_vec[P_N]   = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy.rne) | (n1 & w1 & rxy.rnw)) & cx.cn;
        min_vec[P_E]   = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy.ren) | (e1 & s1 & rxy.res)) & cx.ce;
        min_vec[P_W]   = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy.rwn) | (w1 & s1 & rxy.rws)) & cx.cw;
        min_vec[P_S]   = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy.rse) | (s1 & w1 & rxy.rsw)) & cx.cs;
        min_vec[P_L]   = ~(n1 | e1 | w1 | s1);
    end

`ifdef LBDR_DEROUTE_EN
    logic [1:0]      quad;
    logic [1:0]      sel;
    logic [CX_W-1:0] drt_vec;

    // Quadrant {south, west} picks a 2-bit port code {N,E,W,S} from drt
    assign quad    = {s1, w1};
    assign sel     = drt[{quad, 1'b0} +: 2];
    assign drt_vec = (CX_W'(1) << sel) & CX_W'(cx);
    assign route   = (min_vec == '0) ? {1'b0, drt_vec} : min_vec;
`else
    assign route   = min_vec;
`endif

endmodule

// File: rtl/lbdr_route_stage.sv
// LBDR route stage for one router input port: routes headers, latches the
// port for the rest of the packet, one-flit register slice. Option: LBDR_DEROUTE_EN.
module lbdr_route_stage
    import lbdr_pkg::*;
#(
    parameter int unsigned      XW      = 2,
    parameter int unsigned      YW      = 2,
    parameter int unsigned      DW      = 32,
    parameter logic [7:0]       RXY_RST = 8'h3C,
    parameter logic [3:0]       CX_RST  = 4'hF,
    parameter logic [XW+YW-1:0] CUR_RST = (XW+YW)'(5)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [RXY_W-1:0]    cfg_rxy,
    input  logic [CX_W-1:0]     cfg_cx,
    input  logic [XW+YW-1:0]    cfg_cur,
    input  logic [RXY_W-1:0]    cfg_drt,
    output logic                cfg_busy,
    lbdr_route_stage_if.slave   bus,
    output logic                err
);
    lbdr_state_t       state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    port_vec_t         out_port_q, out_port_d;
    logic              err_q, err_d;
    port_vec_t         port_q, port_d;
    rxy_t              rxy_q;
    cx_t               cx_q;
    logic [XW+YW-1:0]  cur_q;
    port_vec_t         route;
    logic              in_xfer, is_hdr, is_tail, new_hdr, fwd;
    port_vec_t         fwd_port;

    assign bus.in_ready  = ~out_valid_q | bus.out_ready;
    assign cfg_busy      = (state_q != IDLE) | out_valid_q;
    assign in_xfer       = bus.in_valid & bus.in_ready;
    assign is_hdr        = bus.in_id == FLIT_HEADER;
    assign is_tail       = bus.in_id == FLIT_TAIL;

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_port  = out_port_q;
    assign err           = err_q;

`ifdef LBDR_DEROUTE_EN
    logic [RXY_W-1:0] drt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      drt_q <= '0;
        else if (cfg_we && !cfg_busy)  drt_q <= cfg_drt;
    end

    lbdr_route_calc #(.XW(XW), .YW(YW)) u_calc (
        .dst   (bus.in_dst),
        .cur   (cur_q),
        .rxy   (rxy_q),
        .cx    (cx_q),
        .drt   (drt_q),
        .route (route)
    );
`else
    logic unused_drt;
    assign unused_drt = ^cfg_drt;

    lbdr_route_calc #(.XW(XW), .YW(YW)) u_calc (
        .dst   (bus.in_dst),
        .cur   (cur_q),
        .rxy   (rxy_q),
        .cx    (cx_q),
        .route (route)
    );
`endif

    // Configuration loads only while idle and empty; headers use the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxy_q <= rxy_t'(RXY_RST);
            cx_q  <= cx_t'(CX_RST);
            cur_q <= CUR_RST;
        end else if (cfg_we && !cfg_busy) begin
            rxy_q <= rxy_t'(cfg_rxy);
            cx_q  <= cx_t'(cfg_cx);
            cur_q <= cfg_cur;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            err_q       <= 1'b0;
            port_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            err_q       <= err_d;
            port_q      <= port_d;
        end
    end

    // Packet FSM and output slice; a header in any state is routed afresh
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        err_d       = err_q;
        port_d      = port_q;
        new_hdr     = 1'b0;
        fwd         = 1'b0;
        fwd_port    = port_q;

        if (in_xfer) begin
            case (state_q)
                IDLE: begin
                    if (is_hdr) new_hdr = 1'b1;
                    else        err_d   = 1'b1;
                end
                PKT: begin
                    if (is_hdr) begin
                        err_d   = 1'b1;
                        new_hdr = 1'b1;
                    end else begin
                        fwd = 1'b1;
                        if (is_tail) state_d = IDLE;
                    end
                end
                DROP: begin
                    if (is_hdr) begin
                        err_d   = 1'b1;
                        new_hdr = 1'b1;
                    end else if (is_tail) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (new_hdr) begin
                if (route != '0) begin
                    state_d  = PKT;
                    port_d   = route;
                    fwd      = 1'b1;
                    fwd_port = route;
                end else begin
                    state_d  = DROP;
                    err_d    = 1'b1;
                end
            end

            if (fwd) begin
                out_valid_d = 1'b1;
                out_id_d    = bus.in_id;
                out_data_d  = bus.in_data;
                out_port_d  = fwd_port;
            end
        end
    end

endmodule

// File: tb/tb_lbdr_route_stage.sv
// Bench for lbdr_route_stage: directed scenarios then random packets, all
// checked per cycle against a packet-level reference model.
module tb_lbdr_route_stage;
    import lbdr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_rxy = 8'h3C;
    logic [3:0]  cfg_cx = 4'hF;
    logic [3:0]  cfg_cur = 4'd5;
    logic [7:0]  cfg_drt = 8'h00;
    logic        cfg_busy;
    logic        err;

    always #5 clk = ~clk;

    lbdr_route_stage_if #(.XW(2), .YW(2), .DW(32)) bus ();

    lbdr_route_stage #(.XW(2), .YW(2), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_rxy  (cfg_rxy),
        .cfg_cx   (cfg_cx),
        .cfg_cur  (cfg_cur),
        .cfg_drt  (cfg_drt),
        .cfg_busy (cfg_busy),
        .bus      (bus),
        .err      (err)
    );

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic [4:0]  port;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    bit          pkt_open;
    logic [4:0]  pkt_port;
    bit          m_err;
    logic [7:0]  m_rxy;
    logic [3:0]  m_cx;
    logic [3:0]  m_cur;
    bit          last_in_fire;
    bit          rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Minimal routing from signed hop distances: a productive direction is
    // allowed outright when it is the only axis left, else by its turn bit.
    function automatic logic [4:0] route_ref(logic [3:0] dst, logic [3:0] cur,
                                             logic [7:0] rxy, logic [3:0] cx);
        int dx, dy;
        logic [4:0] r;
        dx = int'(dst[1:0]) - int'(cur[1:0]);
        dy = int'(dst[3:2]) - int'(cur[3:2]);
        r  = 5'b0;
        if (dx == 0 && dy == 0) return 5'b10000;
        if (dy < 0 && cx[0] && (dx == 0 || (dx > 0 ? rxy[0] : rxy[1]))) r[0] = 1'b1;
        if (dx > 0 && cx[1] && (dy == 0 || (dy < 0 ? rxy[2] : rxy[3]))) r[1] = 1'b1;
        if (dx < 0 && cx[2] && (dy == 0 || (dy < 0 ? rxy[4] : rxy[5]))) r[2] = 1'b1;
        if (dy > 0 && cx[3] && (dx == 0 || (dx > 0 ? rxy[6] : rxy[7]))) r[3] = 1'b1;
        return r;
    endfunction

    // Packet-level model: an open packet with port 0 is being discarded
    function automatic void model_flit(logic [2:0] id, logic [3:0] dst, logic [31:0] data);
        logic [4:0] r;
        exp_t e;
        if (id == FLIT_HEADER) begin
            if (pkt_open) m_err = 1'b1;
            r        = route_ref(dst, m_cur, m_rxy, m_cx);
            pkt_open = 1'b1;
            pkt_port = r;
            if (r == 5'b0) m_err = 1'b1;
            else begin
                e = '{id: id, data: data, port: r};
                q.push_back(e);
            end
        end else begin
            if (!pkt_open) m_err = 1'b1;
            else if (pkt_port != 5'b0) begin
                e = '{id: id, data: data, port: pkt_port};
                q.push_back(e);
            end
            if (id == FLIT_TAIL) pkt_open = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        pkt_open = 1'b0;
        pkt_port = 5'b0;
        m_err    = 1'b0;
        m_rxy    = 8'h3C;
        m_cx     = 4'hF;
        m_cur    = 4'd5;
    endfunction

    task automatic tick();
        bit busy_m, ready_m, in_fire;
        @(negedge clk);
        busy_m  = pkt_open || (q.size() != 0);
        ready_m = (q.size() == 0) || (bus.out_ready === 1'b1);
        check("in_ready", 64'(bus.in_ready), 64'(ready_m));
        check("cfg_busy", 64'(cfg_busy), 64'(busy_m));
        check("err", 64'(err), 64'(m_err));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_port", 64'(bus.out_port), 64'(q[0].port));
            check("out_id", 64'(bus.out_id), 64'(q[0].id));
            check("out_data", 64'(bus.out_data), 64'(q[0].data));
        end
        in_fire = (bus.in_valid === 1'b1) && ready_m;
        if (q.size() != 0 && bus.out_ready === 1'b1) void'(q.pop_front());
        if (in_fire) model_flit(bus.in_id, bus.in_dst, bus.in_data);
        if (cfg_we && !busy_m) begin
            m_rxy = cfg_rxy;
            m_cx  = cfg_cx;
            m_cur = cfg_cur;
        end
        last_in_fire = in_fire;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] id, input logic [3:0] dst, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_dst   = dst;
        bus.in_data  = data;
        last_in_fire = 1'b0;
        for (int k = 0; k < 100 && !last_in_fire; k++) tick();
        check("send_accept", 64'(last_in_fire), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) tick();
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic set_cfg(input logic [7:0] rxy, input logic [3:0] cx, input logic [3:0] cur);
        cfg_rxy = rxy;
        cfg_cx  = cx;
        cfg_cur = cur;
        cfg_we  = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        rst          = 1'b0;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_port", 64'(bus.out_port), 64'(0));
        check("rst_out_id", 64'(bus.out_id), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_cfg_busy", 64'(cfg_busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_id     = FLIT_PAYLOAD;
        bus.in_dst    = 4'd0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        do_reset();

        // North from (1,1) to (1,0)
        send(FLIT_HEADER, 4'b0001, 32'hA000_0001);
        check("t1_port_n", 64'(bus.out_port), 64'(5'b00001));
        send(FLIT_TAIL, 4'b0000, 32'hA000_0002);
        drain();

        // North-west with Rnw=0, Rwn=1 goes west
        send(FLIT_HEADER, 4'b0000, 32'hB000_0001);
        check("t2_port_w", 64'(bus.out_port), 64'(5'b00100));
        send(FLIT_TAIL, 4'b0000, 32'hB000_0002);
        drain();

        // Local packet, body flits keep the latched port
        send(FLIT_HEADER, 4'd5, 32'hC000_0000);
        check("t3_hdr_l", 64'(bus.out_port), 64'(5'b10000));
        for (int i = 1; i <= 3; i++) begin
            send(FLIT_PAYLOAD, 4'($urandom), 32'hC000_0000 + 32'(i));
            check("t3_pay_l", 64'(bus.out_port), 64'(5'b10000));
        end
        send(FLIT_TAIL, 4'd0, 32'hC000_0004);
        check("t3_tail_l", 64'(bus.out_port), 64'(5'b10000));
        drain();
        check("t3_idle", 64'(cfg_busy), 64'(0));

        // North link missing: whole packet dropped, sticky error
        set_cfg(8'h3C, 4'hE, 4'd5);
        send(FLIT_HEADER, 4'd1, 32'hD000_0001);
        send(FLIT_PAYLOAD, 4'd1, 32'hD000_0002);
        send(FLIT_TAIL, 4'd1, 32'hD000_0003);
        drain();
        check("t4_err", 64'(err), 64'(1));
        check("t4_no_out", 64'(bus.out_valid), 64'(0));
        do_reset();

        // Downstream stall mid-packet
        send(FLIT_HEADER, 4'd5, 32'hE000_0001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_id     = FLIT_PAYLOAD;
        bus.in_data   = 32'hE000_0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("t5_stall_data", 64'(bus.out_data), 64'(32'hE000_0001));
        end
        bus.out_ready = 1'b1;
        send(FLIT_PAYLOAD, 4'd0, 32'hE000_0002);
        send(FLIT_TAIL, 4'd0, 32'hE000_0003);
        drain();

        // Config write while busy is ignored, accepted once idle
        send(FLIT_HEADER, 4'd0, 32'hF000_0001);
        set_cfg(8'h3C, 4'hF, 4'd0);
        send(FLIT_TAIL, 4'd0, 32'hF000_0002);
        drain();
        send(FLIT_HEADER, 4'd0, 32'hF000_0003);
        check("t6_cfg_ignored", 64'(bus.out_port), 64'(5'b00100));
        send(FLIT_TAIL, 4'd0, 32'hF000_0004);
        drain();
        set_cfg(8'h3C, 4'hF, 4'd0);
        send(FLIT_HEADER, 4'd0, 32'hF000_0005);
        check("t6_cfg_applied", 64'(bus.out_port), 64'(5'b10000));
        send(FLIT_TAIL, 4'd0, 32'hF000_0006);
        drain();

        // Config write together with a header: header sees the old config
        cfg_rxy = 8'h3C;
        cfg_cx  = 4'hF;
        cfg_cur = 4'd5;
        cfg_we  = 1'b1;
        send(FLIT_HEADER, 4'd0, 32'h1000_0001);
        check("t7_old_cfg", 64'(bus.out_port), 64'(5'b10000));
        send(FLIT_TAIL, 4'd0, 32'h1000_0002);
        drain();
        send(FLIT_HEADER, 4'd0, 32'h1000_0003);
        check("t7_new_cfg", 64'(bus.out_port), 64'(5'b00100));
        send(FLIT_TAIL, 4'd0, 32'h1000_0004);
        drain();

        // Reset mid-packet: a following body flit is a protocol error
        send(FLIT_HEADER, 4'd1, 32'h2000_0001);
        send(FLIT_PAYLOAD, 4'd1, 32'h2000_0002);
        do_reset();
        send(FLIT_PAYLOAD, 4'd1, 32'h2000_0003);
        drain();
        check("t8_err", 64'(err), 64'(1));
        check("t8_no_out", 64'(bus.out_valid), 64'(0));
        do_reset();

        // Random packets, random backpressure and configuration
        rnd_ready = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int n_pay;
            if (p % 25 == 24) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                cfg_rxy = 8'($urandom);
                cfg_cx  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                cfg_cur = 4'($urandom);
                cfg_we  = 1'b1;
            end
            send(FLIT_HEADER, 4'($urandom), $urandom);
            n_pay = $urandom_range(0, 3);
            for (int i = 0; i < n_pay; i++) send(FLIT_PAYLOAD, 4'($urandom), $urandom);
            if ($urandom_range(0, 15) != 0) send(FLIT_TAIL, 4'($urandom), $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
